// File: rtl/shift_row_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_row_pkg
// Description : State/row/byte types and ShiftRows permutation functions.
//               The inverse function is used only when SHIFT_ROW_INV_EN is defined.
// Revision    : 1.0
// ============================================================================
package shift_row_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  row_t;
    typedef logic [7:0]   byte_t;

    localparam int NUM_ROWS  = 4;
    localparam int ROW_BYTES = 4;

    // Byte k lives at state[127-8k -: 8]; row r holds bytes 4r..4r+3.
    function automatic state_t shift_rows_fwd(input state_t s);
        state_t o;
        o = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < ROW_BYTES; c++) begin
                o[127 - 8*(ROW_BYTES*r + c) -: 8] =
                    s[127 - 8*(ROW_BYTES*r + ((c + r) % ROW_BYTES)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic state_t shift_rows_inv(input state_t s);
        state_t o;
        o = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < ROW_BYTES; c++) begin
                o[127 - 8*(ROW_BYTES*r + c) -: 8] =
                    s[127 - 8*(ROW_BYTES*r + ((c - r + ROW_BYTES) % ROW_BYTES)) -: 8];
            end
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_row_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_row_if
// Description : Valid/ready handshake bundle for the ShiftRows stage.
//               SHIFT_ROW_INV_EN adds the inv select signal.
// Revision    : 1.0
// ============================================================================
interface shift_row_if;
    import shift_row_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_data;
    logic   out_valid;
    logic   out_ready;
    state_t out_data;
    state_t comb_data;
`ifdef SHIFT_ROW_INV_EN
    logic   inv;

    modport master (
        output in_valid, in_data, out_ready, inv,
        input  in_ready, out_valid, out_data, comb_data
    );
    modport slave (
        input  in_valid, in_data, out_ready, inv,
        output in_ready, out_valid, out_data, comb_data
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, comb_data
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, comb_data
    );
`endif
endinterface
`default_nettype wire

// File: rtl/shift_row_perm.sv
`default_nettype none
// ============================================================================
// Module      : shift_row_perm
// Description : Combinational ShiftRows byte permutation; SHIFT_ROW_INV_EN
//               adds an inv select for the inverse permutation.
// Revision    : 1.0
// ============================================================================
module shift_row_perm
    import shift_row_pkg::*;
(
    input  state_t data_in,
`ifdef SHIFT_ROW_INV_EN
    input  logic   inv,
`endif
    output state_t data_out
);

`ifdef SHIFT_ROW_INV_EN
    assign data_out = inv ? shift_rows_inv(data_in) : shift_rows_fwd(data_in);
`else
    assign data_out = shift_rows_fwd(data_in);
`endif

endmodule
`default_nettype wire

// File: rtl/shift_row.sv
`default_nettype none
// ============================================================================
// Module      : shift_row
// Description : ShiftRows stage with optional one-deep valid/ready register.
//               SHIFT_ROW_INV_EN enables the inverse-permutation select.
// Revision    : 1.0
// ============================================================================
module shift_row
    import shift_row_pkg::*;
#(
    parameter int REGISTERED = 1
) (
    input  logic       clk,
    input  logic       rst,
    shift_row_if.slave bus
);

    state_t w_perm;

    shift_row_perm u_perm (
        .data_in  (bus.in_data),
`ifdef SHIFT_ROW_INV_EN
        .inv      (bus.inv),
`endif
        .data_out (w_perm)
    );

    assign bus.comb_data = w_perm;

    generate
        if (REGISTERED != 0) begin : g_reg
            logic   r_out_valid;
            state_t r_out_data;
            logic   w_in_ready;

            // Reset forces ready so upstream never stalls on a flushing stage.
            assign w_in_ready = rst || !r_out_valid || bus.out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                end else if (bus.in_valid && w_in_ready) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_perm;
                end else if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end

            assign bus.in_ready  = w_in_ready;
            assign bus.out_valid = r_out_valid;
            assign bus.out_data  = r_out_data;
        end else begin : g_comb
            assign bus.in_ready  = bus.out_ready;
            assign bus.out_valid = bus.in_valid;
            assign bus.out_data  = w_perm;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_shift_row.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_row
// Description : Scoreboard bench for shift_row (registered and pass-through).
// Revision    : 1.0
// ============================================================================
module tb_shift_row;
    import shift_row_pkg::*;

    localparam state_t KIN  = 128'h87F24D97EC6E4C904AC346E78CD895A6;
    localparam state_t KOUT = 128'h87F24D976E4C90EC46E74AC3A68CD895;
    localparam state_t IIN  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam state_t IOUT = 128'h00010203050607040A0B08090F0C0D0E;
`ifdef SHIFT_ROW_INV_EN
    localparam int EXP_POPS = 13;
`else
    localparam int EXP_POPS = 12;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_row_if bus ();
    shift_row_if bus0 ();

    shift_row #(.REGISTERED(1)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    shift_row #(.REGISTERED(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int     errors = 0;
    int     checks = 0;
    int     n_pop  = 0;
    state_t cur_exp;
    state_t sb[$];

    task automatic chk(input string name, input state_t act, input state_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop on output handshake, push on input acceptance, flush on reset.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            n_pop++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected none", bus.out_data);
            end else begin
                chk("sb_out_data", bus.out_data, sb.pop_front());
            end
        end
        if (rst)
            sb.delete();
        else if (bus.in_valid && bus.in_ready)
            sb.push_back(cur_exp);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        state_t r, t, e;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 'x; bus.out_ready = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
`ifdef SHIFT_ROW_INV_EN
        bus.inv = 1'b0; bus0.inv = 1'b0;
`endif
        cur_exp = '0;
        step(); step();
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        rst = 1'b0;
        step();
        chk("idle_x_out_data", bus.out_data, '0);

        // Known vector: combinational result and 1-cycle latency
        bus.in_valid = 1'b1; bus.in_data = KIN; cur_exp = KOUT;
        #1 chk("known_comb", bus.comb_data, KOUT);
        step();
        bus.in_valid = 1'b0; bus.in_data = 'x;
        chk("known_lat_valid", 128'(bus.out_valid), 128'd1);
        chk("known_lat_data", bus.out_data, KOUT);
        step();

        // Back-to-back burst: one result per cycle
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = IIN  | {16{8'(k << 4)}};
            cur_exp      = IOUT | {16{8'(k << 4)}};
            step();
            chk("burst_valid", 128'(bus.out_valid), 128'd1);
            chk("burst_data", bus.out_data, cur_exp);
        end
        bus.in_valid = 1'b0; bus.in_data = 'x;
        step();
        chk("burst_drain_valid", 128'(bus.out_valid), 128'd0);

        // Backpressure: hold, then drain and fill in the same cycle
        bus.in_valid = 1'b1; bus.in_data = KIN; cur_exp = KOUT;
        step();
        bus.out_ready = 1'b0; bus.in_data = IIN; cur_exp = IOUT;
        #1 chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("bp_hold_data", bus.out_data, KOUT);
            chk("bp_hold_valid", 128'(bus.out_valid), 128'd1);
            chk("bp_hold_ready", 128'(bus.in_ready), 128'd0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.in_data = 'x;
        chk("bp_release_data", bus.out_data, IOUT);
        step();
        chk("bp_release_valid", 128'(bus.out_valid), 128'd0);

        // Reset mid-stream drops the held word and the one presented with rst
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = KIN; cur_exp = KOUT;
        step();
        rst = 1'b1; bus.in_data = IIN; cur_exp = IOUT;
        #1 chk("rst_mid_in_ready", 128'(bus.in_ready), 128'd1);
        step();
        chk("rst_mid_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_mid_out_data", bus.out_data, '0);
        chk("rst_mid_in_ready2", 128'(bus.in_ready), 128'd1);
        rst = 1'b0; bus.out_ready = 1'b1; bus.in_data = KIN; cur_exp = KOUT;
        step();
        bus.in_valid = 1'b0; bus.in_data = 'x;
        chk("post_rst_data", bus.out_data, KOUT);
        step();

`ifdef SHIFT_ROW_INV_EN
        bus.inv = 1'b1; bus.in_valid = 1'b1; bus.in_data = KOUT; cur_exp = KIN;
        #1 chk("inv_comb", bus.comb_data, KIN);
        step();
        bus.inv = 1'b0; bus.in_valid = 1'b0; bus.in_data = 'x;
        chk("inv_reg", bus.out_data, KIN);
        step();
        for (int k = 0; k < 4; k++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            bus0.inv = 1'b0; bus0.in_data = r;
            #1 t = bus0.comb_data;
            bus0.inv = 1'b1; bus0.in_data = t;
            #1 chk("inv_roundtrip", bus0.comb_data, r);
        end
        bus0.inv = 1'b0;
`endif

        // Pass-through configuration
        bus0.in_data = KIN;
        for (int k = 0; k < 4; k++) begin
            bus0.in_valid  = k[0];
            bus0.out_ready = k[1];
            #1;
            chk("comb0_out_valid", 128'(bus0.out_valid), 128'(k[0]));
            chk("comb0_in_ready", 128'(bus0.in_ready), 128'(k[1]));
            chk("comb0_out_data", bus0.out_data, KOUT);
        end
        bus0.in_data = IIN;
        #1 e = IOUT;
        chk("comb0_idx_data", bus0.out_data, e);
        chk("comb0_idx_comb", bus0.comb_data, e);

        step(); step();
        chk("sb_empty", 128'(sb.size()), 128'd0);
        chk("sb_pop_count", 128'(n_pop), 128'(EXP_POPS));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_row.md
Name: shift_row

Overview:
- Haraka/AES-style ShiftRows byte permutation on a 128-bit state.
- The state is viewed as four 32-bit rows, most significant first. Row r is rotated left by r bytes.
- Wrapped in a one-stage registered valid/ready pipeline stage. It sits between the SubBytes and MixColumns stages of the round datapath.
- Also exposes the pure combinational result for zero-latency use.

Parameters:
- REGISTERED, 1, 1 = output registered (1-cycle latency); 0 = out_* driven combinationally from in_*.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  input word valid
- in_ready  output  1  stage can accept input this cycle
- in_data  input  128  state to permute
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  permuted state
- comb_data  output  128  combinational permutation of in_data, independent of handshake/reset

Behaviour:
- Byte numbering:
  - byte k = data[127-8k -: 8], k = 0..15.
  - Row r = bytes 4r..4r+3, i.e. data[127-32r -: 32].
- Forward permutation: out byte 4r+c = in byte 4r+((c+r) mod 4).
  - Row 0 unchanged.
  - Row 1 rotated left 8 bits.
  - Row 2 rotated left 16 bits.
  - Row 3 rotated left 24 bits.
- Pure wiring, no arithmetic. comb_data always equals the permutation of the current in_data.
- REGISTERED=1:
  - Transfer in when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (full-throughput, single register, no skid buffer).
  - On transfer: out_data <= perm(in_data), out_valid <= 1, visible the next cycle (latency 1).
  - If out_valid && out_ready && no input transfer: out_valid <= 0.
  - Simultaneous drain and fill in the same cycle: the new word replaces the old one, and out_valid stays 1.
  - Under backpressure (out_valid && !out_ready): out_data and out_valid hold; in_ready = 0.
- REGISTERED=0:
  - out_valid = in_valid, in_ready = out_ready, out_data = comb_data.
  - rst has no effect.
- Reset (rst high at a clock edge):
  - out_valid <= 0 and out_data <= 0, regardless of in_valid or in-flight data.
  - in_ready = 1 during and after reset.
  - A word presented in the reset cycle is dropped.
- X on in_data while in_valid=0 must not propagate into out_data.

Optional Feature:
- Macro SHIFT_ROW_INV_EN.
- Defined:
  - Adds input port inv (1 bit), sampled with in_data.
  - inv=1 selects the inverse permutation: out byte 4r+c = in byte 4r+((c-r) mod 4), i.e. row r rotated right by r bytes.
  - inv applies to both comb_data and the registered path.
  - inv=0 is identical to the forward permutation.
- Not defined: no inv port; forward permutation only.

Decomposition:
- Package shift_row_pkg:
  - typedef state_t (logic [127:0]), row_t (logic [31:0]), byte_t (logic [7:0]).
  - Constants NUM_ROWS=4, ROW_BYTES=4.
  - Functions shift_rows_fwd(state_t) and shift_rows_inv(state_t).
- One sub-module is natural: shift_row_perm, the combinational permutation (forward/inverse select).
- The top shift_row adds the handshake register around shift_row_perm.

Test Plan:
- Known vector:
  - in_data=87F24D97EC6E4C904AC346E78CD895A6 -> comb_data and out_data (next cycle) = 87F24D976E4C90EC46E74AC3A68CD895.
- Byte-index vector:
  - in_data=000102030405060708090A0B0C0D0E0F -> 00010203050607040A0B08090F0C0D0E.
  - Run with in_valid held high for 8 cycles with out_ready=1: one result per cycle, latency 1.
- Backpressure:
  - out_ready=0 after the first result -> out_data holds 87F24D976E4C90EC46E74AC3A68CD895, in_ready=0.
  - Release out_ready -> the next word is accepted and no word is lost or duplicated.
- Reset:
  - rst=1 mid-stream with out_valid=1 -> out_valid=0 and out_data=0 after the edge, in_ready=1.
  - First word after rst deasserts is accepted normally.
- Inverse (SHIFT_ROW_INV_EN):
  - inv=1, in_data=87F24D976E4C90EC46E74AC3A68CD895 -> 87F24D97EC6E4C904AC346E78CD895A6.
  - Random vectors: inverse of forward equals input.
- REGISTERED=0:
  - out_data equals comb_data in the same cycle.
  - out_valid tracks in_valid and in_ready tracks out_ready.
